seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//   Sequential signed divider, the inverse of the 32x32->64 Wallace-tree multiplier.
//   Divides a 2*W-bit two's-complement dividend by a W-bit divisor to give a W-bit quotient and remainder.
//   Uses radix-2 restoring shift-subtract on magnitudes, one quotient bit per clock.
//   Valid/ready handshakes on input and output; it sits beside the multiplier in the arithmetic datapath.
// PARAMETERS
//   W   32   operand width; dividend is 2*W bits, divisor/quotient/remainder are W bits
// PORTS
//   clk          in   1    single clock, all state on rising edge
//   rst_n        in   1    reset, synchronous, active-low
//   in_valid     in   1    dividend/divisor valid
//   in_ready     out  1    block idle, can accept an operation
//   dividend     in   2W   signed dividend
//   divisor      in   W    signed divisor
//   out_valid    out  1    result valid; held until accepted
//   out_ready    in   1    consumer accepts result
//   quotient     out  W    signed quotient, truncated toward zero
//   remainder    out  W    signed remainder, sign of dividend (or zero)
//   div_by_zero  out  1    divisor was 0
//   overflow     out  1    true quotient not representable in W signed bits
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE; out_valid, quotient, remainder, div_by_zero, overflow all 0.
//     Reset mid-operation aborts it; the operand is discarded and no result is produced.
//   in_ready = (state==IDLE), decoded from state; it is 1 immediately after reset.
//   States and transitions:
//     IDLE -> CALC on in_valid&in_ready (edge 0).
//       Latch |dividend|, |divisor|, sign_q = sign(dividend)^sign(divisor), sign_r = sign(dividend).
//     IDLE -> DONE at edge 0 when divisor==0:
//       quotient = all ones, remainder = dividend[W-1:0], div_by_zero=1, overflow=0.
//     IDLE -> DONE at edge 0 when |dividend|[2W-1:W] >= |divisor| (magnitude overflow):
//       quotient=0, remainder=0, overflow=1, div_by_zero=0.
//       Divide-by-zero takes priority over overflow.
//     CALC: edges 1..W, one iteration per edge, quotient bits MSB first.
//       Partial remainder is W+1 bits wide: shift left, bring in the next dividend bit, subtract |divisor| if no borrow.
//       After the W-th iteration the state goes to FIX.
//     FIX (edge W+1): apply the signs and register the outputs, then go to DONE.
//       quotient = sign_q ? -|q| : |q|; remainder = sign_r ? -|r| : |r|.
//       overflow=1 if |q| > 2^(W-1)-1 with sign_q=0, or |q| > 2^(W-1) with sign_q=1.
//       On signed overflow, quotient and remainder are forced to 0.
//     DONE: out_valid=1 and the outputs are stable. On out_valid&out_ready -> IDLE and out_valid=0.
//   Latency: a normal result is visible after edge W+2 (34 clocks for W=32). Early exits are visible after edge 1.
//   One operation in flight. in_valid is ignored when in_ready=0.
//   out_ready is ignored outside DONE. Output holds indefinitely under back-pressure.
//   Accept in the same cycle as a result is taken: impossible (in_ready=0 in DONE); next accept is the following cycle.
//   Magnitude of the most negative input uses a (2W+1)/(W+1)-bit intermediate; no wrap.
// TESTING
//   1. dividend=100, divisor=7 -> quotient=14, remainder=2, flags 0; out_valid 34 clocks after accept.
//   2. Signs: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1.
//   3. Inverse check: for 500 random a,b with b!=0, take c=a*b from the wallace multiplier -> quotient=a, remainder=0.
//   4. Boundaries: divisor=0 -> div_by_zero=1 after 1 edge;
//      dividend=2^32, divisor=1 -> overflow=1 after 1 edge;
//      dividend=2^31, divisor=1 -> overflow=1 via FIX;
//      dividend=-2^31, divisor=1 -> q=0x80000000, no overflow;
//      dividend=-2^31, divisor=-1 -> overflow=1.
//   5. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0; pulse out_ready -> IDLE next edge.
//      in_valid during CALC has no effect.
//   6. Assert rst_n=0 at CALC iteration 10 -> next edge: IDLE, out_valid=0, all outputs 0.
//      A new operation afterwards gives a correct result.

Source files
------------

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Signed 2W/W radix-2 restoring divider, one quotient bit per
//                clock, with valid/ready handshakes on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_last_iter = CW'(W - 1);
  localparam logic [W-1:0]  c_min_mag   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state, w_next;
  logic            r_out_valid;
  logic [W:0]      r_rem;
  logic [W-1:0]    r_low;
  logic [W:0]      r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_sign_q, r_sign_r;
  logic [W-1:0]    r_quotient, r_remainder;
  logic            r_dbz, r_ovf;

  logic [2*W:0]    w_dvd_ext, w_dvd_mag;
  logic [W:0]      w_dvs_ext, w_dvs_mag;
  logic            w_dbz, w_mag_ovf;
  logic [W+1:0]    w_shift, w_diff;
  logic            w_borrow, w_fix_ovf;
  logic [W-1:0]    w_q_signed, w_r_signed;

  // One extra bit on each magnitude so the most negative operand cannot wrap.
  assign w_dvd_ext = {dividend[2*W-1], dividend};
  assign w_dvd_mag = dividend[2*W-1] ? -w_dvd_ext : w_dvd_ext;
  assign w_dvs_ext = {divisor[W-1], divisor};
  assign w_dvs_mag = divisor[W-1] ? -w_dvs_ext : w_dvs_ext;
  assign w_dbz     = (divisor == '0);
  assign w_mag_ovf = (w_dvd_mag[2*W:W] >= w_dvs_mag);

  // r_low holds the remaining dividend bits and collects quotient bits behind them.
  assign w_shift  = {r_rem, r_low[W-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_borrow = w_diff[W+1];

  assign w_fix_ovf  = r_sign_q ? (r_low > c_min_mag) : r_low[W-1];
  assign w_q_signed = r_sign_q ? -r_low : r_low;
  assign w_r_signed = r_sign_r ? -r_rem[W-1:0] : r_rem[W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (r_state == S_DONE) && !(r_out_valid && out_ready);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = (w_dbz || w_mag_ovf) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == c_last_iter) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (r_out_valid && out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_low       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rem    <= w_dvd_mag[2*W:W];
            r_low    <= w_dvd_mag[W-1:0];
            r_dvs    <= w_dvs_mag;
            r_cnt    <= '0;
            r_sign_q <= dividend[2*W-1] ^ divisor[W-1];
            r_sign_r <= dividend[2*W-1];
            if (w_dbz) begin
              r_quotient  <= '1;
              r_remainder <= dividend[W-1:0];
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
            end else if (w_mag_ovf) begin
              r_quotient  <= '0;
              r_remainder <= '0;
              r_dbz       <= 1'b0;
              r_ovf       <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_borrow ? w_shift[W:0] : w_diff[W:0];
          r_low <= {r_low[W-2:0], ~w_borrow};
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          r_dbz       <= 1'b0;
          r_ovf       <= w_fix_ovf;
          r_quotient  <= w_fix_ovf ? '0 : w_q_signed;
          r_remainder <= w_fix_ovf ? '0 : w_r_signed;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

`default_nettype wire
